// File: rtl/dpram_arb.sv
// Two-requester round-robin arbiter in front of one dpram port.
// After reset it fills every RAM location with FILL, then arbitrates single-cycle transfers.

module dpram_arb_rd (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_i,
  input  logic [7:0] ram_dout_i,
  output logic       rvalid_o,
  output logic [7:0] rdata_o
);
  logic rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) rvalid_q <= 1'b0;
    else     rvalid_q <= rd_i;
  end

  // Reset in the data cycle cancels the pending return.
  assign rvalid_o = rvalid_q & ~rst;
  assign rdata_o  = rvalid_o ? ram_dout_i : 8'h00;
endmodule

module dpram_arb #(
  parameter logic [7:0] FILL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] addr0,
  input  logic [7:0] din0,
  output logic       gnt0,
  output logic       rvalid0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] addr1,
  input  logic [7:0] din1,
  output logic       gnt1,
  output logic       rvalid1,
  output logic [7:0] rdata1,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_we,
  input  logic [7:0] ram_dout,
  output logic       init_done
);
  localparam int NREQ = 2;

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  typedef struct packed {
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] din;
  } req_t;

  req_t [NREQ-1:0] rq;
  state_e          state_q;
  logic [7:0]      cnt_q;
  logic            ptr_q, ptr_d;
  logic            init_done_q;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rvalid;
  logic [NREQ-1:0][7:0] rdata;

  assign rq[0] = '{req: req0, we: we0, addr: addr0, din: din0};
  assign rq[1] = '{req: req1, we: we1, addr: addr1, din: din1};

  // On conflict the requester other than the last winner goes.
  always_comb begin
    gnt = '0;
    if (!rst && state_q == ST_RUN) begin
      if (rq[0].req && rq[1].req) gnt = ptr_q ? 2'b01 : 2'b10;
      else                        gnt = {rq[1].req, rq[0].req};
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0])      ptr_d = 1'b0;
    else if (gnt[1]) ptr_d = 1'b1;
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = 8'h00;
    ram_din  = 8'h00;
    if (rst || state_q == ST_INIT) begin
      ram_we   = 1'b1;
      ram_addr = rst ? 8'h00 : cnt_q;
      ram_din  = FILL;
    end else if (gnt[0]) begin
      ram_we   = rq[0].we;
      ram_addr = rq[0].addr;
      ram_din  = rq[0].din;
    end else if (gnt[1]) begin
      ram_we   = rq[1].we;
      ram_addr = rq[1].addr;
      ram_din  = rq[1].din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= 8'h00;
      ptr_q       <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'hFF) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN:  ptr_q <= ptr_d;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_rd
    dpram_arb_rd u_rd (
      .clk        (clk),
      .rst        (rst),
      .rd_i       (gnt[g] & ~rq[g].we),
      .ram_dout_i (ram_dout),
      .rvalid_o   (rvalid[g]),
      .rdata_o    (rdata[g])
    );
  end

  assign gnt0      = gnt[0];
  assign gnt1      = gnt[1];
  assign rvalid0   = rvalid[0];
  assign rvalid1   = rvalid[1];
  assign rdata0    = rdata[0];
  assign rdata1    = rdata[1];
  assign init_done = init_done_q & ~rst;
endmodule

// File: tb/tb_dpram_arb.sv
// Randomized bench for dpram_arb against a cycle-level behavioural model and a RAM model.

module tb_dpram_arb;
  localparam logic [7:0] FILL = 8'h3C;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, din0, addr1, din1;
  logic       gnt0, gnt1, rvalid0, rvalid1, ram_we, init_done;
  logic [7:0] rdata0, rdata1, ram_addr, ram_din, ram_dout;

  int n_chk = 0;
  int n_err = 0;

  dpram_arb #(.FILL(FILL)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM port: read data appears the cycle after the address.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // Reference model state.
  bit         m_init = 1'b1;
  int         m_cnt  = 0;
  int         m_last = 1;
  bit         m_pend [2];
  logic [7:0] m_pdat [2];
  logic [7:0] m_mem  [256];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit q0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                     input bit q1, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
    int g;
    bit e_we;
    logic [7:0] e_addr, e_din;
    bit rq [2];
    bit wq [2];
    logic [7:0] aq [2];
    logic [7:0] dq [2];
    rst = r; req0 = q0; we0 = w0; addr0 = a0; din0 = d0;
    req1 = q1; we1 = w1; addr1 = a1; din1 = d1;
    rq[0] = q0; rq[1] = q1; wq[0] = w0; wq[1] = w1;
    aq[0] = a0; aq[1] = a1; dq[0] = d0; dq[1] = d1;
    #3;
    g = -1;
    if (!r && !m_init) begin
      if (rq[0] && rq[1]) g = 1 - m_last;
      else if (rq[0])     g = 0;
      else if (rq[1])     g = 1;
    end
    if (r || m_init) begin
      e_we = 1'b1; e_addr = r ? 8'h00 : 8'(m_cnt); e_din = FILL;
    end else if (g >= 0) begin
      e_we = wq[g]; e_addr = aq[g]; e_din = dq[g];
    end else begin
      e_we = 1'b0; e_addr = 8'h00; e_din = 8'h00;
    end
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_din", 32'(ram_din), 32'(e_din));
    chk("init_done", 32'(init_done), 32'(!r && !m_init));
    chk("rvalid0", 32'(rvalid0), 32'(!r && m_pend[0]));
    chk("rvalid1", 32'(rvalid1), 32'(!r && m_pend[1]));
    chk("rdata0", 32'(rdata0), (!r && m_pend[0]) ? 32'(m_pdat[0]) : 32'h0);
    chk("rdata1", 32'(rdata1), (!r && m_pend[1]) ? 32'(m_pdat[1]) : 32'h0);
    m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    if (r) begin
      m_init = 1'b1; m_cnt = 0; m_last = 1;
    end else if (m_init) begin
      m_mem[m_cnt] = FILL;
      if (m_cnt == 255) m_init = 1'b0;
      m_cnt = (m_cnt + 1) % 256;
    end else if (g >= 0) begin
      m_last = g;
      if (wq[g]) m_mem[aq[g]] = dq[g];
      else begin m_pend[g] = 1'b1; m_pdat[g] = m_mem[aq[g]]; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r);
    cyc(r, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic rnd(input bit r);
    cyc(r, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
  endtask

  initial begin
    idle(1); idle(1);
    // Init with random (ignored) requests.
    for (int i = 0; i < 256; i++) rnd(0);
    chk("init_after_256", 32'(m_init), 32'h0);
    cyc(0, 1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
    idle(0);
    // Write then cross-requester readback.
    cyc(0, 1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
    chk("rd_a5_expect", 32'(m_pdat[1]), 32'hA5);
    idle(0);
    // Continuous conflict: grants must alternate.
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
    idle(0);
    // Lone req1, then first conflict goes to req0.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h03, 8'h00);
    cyc(0, 1, 0, 8'h04, 8'h00, 1, 0, 8'h05, 8'h00);
    chk("conflict_to_req0", 32'(m_last), 32'h0);
    idle(0);
    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rnd($urandom_range(0, 199) == 0);
      if (m_init) while (m_init) rnd(0);
    end
    // Reset pulse mid-init at counter 0x40.
    idle(1);
    while (m_cnt != 8'h40) rnd(0);
    idle(1);
    for (int i = 0; i < 256; i++) begin
      chk("init_hold", 32'(init_done), 32'h0);
      rnd(0);
    end
    // Reset the cycle after a granted read.
    cyc(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    idle(1);
    idle(0);
    for (int i = 0; i < 20; i++) rnd(0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
